// File: rtl/sd_blk_arb.sv
// Two-client round-robin arbiter sharing one SD block-device host port.
// Optional request-to-ack timeout is compiled in with `define SD_ARB_TIMEOUT_EN.
module sd_blk_arb #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_500_000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] req_lba      [2],
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  output logic [1:0]  req_ack,
  input  logic [7:0]  req_buff_din [2],
  output logic [1:0]  req_buff_wr,
  output logic [1:0]  req_err,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, DONE} state_t;

  state_t      state_q;
  logic        owner_q;
  logic        last_q;
  logic [31:0] sd_lba_q;
  logic        sd_rd_q;
  logic        sd_wr_q;

  logic [1:0]  pending;
  logic        gnt_valid_d;
  logic        gnt_idx_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pending     = req_rd | req_wr;
    gnt_valid_d = 1'b0;
    gnt_idx_d   = 1'b0;
    if (pending != 2'b00) begin
      gnt_valid_d = 1'b1;
      // On a tie the client that was not served last wins; otherwise the lone requester.
      gnt_idx_d   = (pending == 2'b11) ? ~last_q : pending[1];
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;
  logic [1:0]  req_err_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      sd_lba_q  <= 32'h0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt_q <= 24'h0;
      req_err_q <= 2'b00;
`endif
    end else begin
`ifdef SD_ARB_TIMEOUT_EN
      req_err_q <= 2'b00;
`endif
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            state_q   <= ISSUE;
            owner_q   <= gnt_idx_d;
            sd_lba_q  <= req_lba[gnt_idx_d];
            sd_rd_q   <= req_rd[gnt_idx_d];
            sd_wr_q   <= ~req_rd[gnt_idx_d];
`ifdef SD_ARB_TIMEOUT_EN
            tmo_cnt_q <= 24'h0;
`endif
          end
        end
        ISSUE: begin
          if (sd_ack) begin
            state_q <= ACTIVE;
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYC - 24'd1) begin
            state_q            <= DONE;
            sd_rd_q            <= 1'b0;
            sd_wr_q            <= 1'b0;
            req_err_q[owner_q] <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 24'd1;
          end
`endif
        end
        ACTIVE: begin
          if (!sd_ack) state_q <= DONE;
        end
        DONE: begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  assign req_err = req_err_q;
`else
  assign req_err = 2'b00;
`endif

  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  // Host strobes and data pass straight through to the owner with no added latency.
  assign req_ack     = (sd_ack && busy)     ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign req_buff_wr = (sd_buff_wr && busy) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign sd_buff_din = busy ? req_buff_din[owner_q] : 8'h00;

endmodule

// File: tb/tb_sd_blk_arb.sv
// Directed testbench for sd_blk_arb: grant order, pass-through gating, reset and timeout.
// Build with +define+SD_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_sd_blk_arb;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] req_lba      [2];
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [1:0]  req_ack;
  logic [7:0]  req_buff_din [2];
  logic [1:0]  req_buff_wr;
  logic [1:0]  req_err;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        busy;
  logic        owner;

  int n_checks = 0;
  int n_errors = 0;

  sd_blk_arb #(.TIMEOUT_CYC(24'd16)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .req_lba      (req_lba),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .req_buff_din (req_buff_din),
    .req_buff_wr  (req_buff_wr),
    .req_err      (req_err),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .owner        (owner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // From ISSUE: ack for n_ack cycles (owner drops its request), then walk DONE -> IDLE.
  task automatic finish_xfer(input int idx, input int n_ack);
    sd_ack      = 1'b1;
    req_rd[idx] = 1'b0;
    req_wr[idx] = 1'b0;
    repeat (n_ack) tick();
    sd_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [7:0] d;
    RESET_N = 1'b0; req_rd = 2'b00; req_wr = 2'b00;
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    req_lba[0] = 32'h0; req_lba[1] = 32'h0;
    req_buff_din[0] = 8'h3C; req_buff_din[1] = 8'hC3;
    #1;
    // Reset state, with host strobes active to show the gating
    check("rst_busy", busy, 0);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_sd_lba", sd_lba, 0);
    check("rst_owner", owner, 0);
    check("rst_req_ack", req_ack, 2'b00);
    check("rst_buff_wr", req_buff_wr, 2'b00);
    check("rst_buff_din", sd_buff_din, 8'h00);
    check("rst_req_err", req_err, 2'b00);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Single read from client 0 with a 3-cycle ack
    req_lba[0] = 32'h0000_0123; req_lba[1] = 32'hDEAD_BEEF; req_rd = 2'b01;
    #1 check("r0_pre_grant_busy", busy, 0);
    tick();
    check("r0_sd_rd", sd_rd, 1);
    check("r0_sd_wr", sd_wr, 0);
    check("r0_sd_lba", sd_lba, 32'h123);
    check("r0_owner", owner, 0);
    check("r0_busy", busy, 1);
    req_lba[0] = 32'h0000_FFFF;
    sd_ack = 1'b1;
    #1 check("r0_ack_c1", req_ack, 2'b01);
    req_rd = 2'b00;
    tick();
    check("r0_sd_rd_low", sd_rd, 0);
    check("r0_ack_c2", req_ack, 2'b01);
    check("r0_lba_stable", sd_lba, 32'h123);
    tick();
    check("r0_ack_c3", req_ack, 2'b01);
    sd_ack = 1'b0;
    #1 check("r0_ack_off", req_ack, 2'b00);
    tick();
    check("r0_done_busy", busy, 1);
    check("r0_done_lba", sd_lba, 32'h123);
    tick();
    check("r0_idle_busy", busy, 0);

    // Simultaneous requests after reset: client 0 first, then client 1 after DONE + IDLE
    do_reset();
    req_lba[0] = 32'h1000; req_lba[1] = 32'h2000; req_rd = 2'b11;
    tick();
    check("tie_owner0", owner, 0);
    check("tie_lba0", sd_lba, 32'h1000);
    sd_ack = 1'b1; req_rd[0] = 1'b0;
    #1 check("tie_ack_owner_only", req_ack, 2'b01);
    tick();
    sd_ack = 1'b0;
    tick();
    check("tie_done_sd_rd", sd_rd, 0);
    check("tie_done_busy", busy, 1);
    tick();
    check("tie_idle_busy", busy, 0);
    check("tie_idle_sd_rd", sd_rd, 0);
    tick();
    check("tie_c1_sd_rd", sd_rd, 1);
    check("tie_c1_owner", owner, 1);
    check("tie_c1_lba", sd_lba, 32'h2000);
    finish_xfer(1, 2);
    // Client 1 served last, so a fresh tie goes to client 0
    req_rd = 2'b11;
    tick();
    check("rr_after1_owner", owner, 0);
    finish_xfer(0, 1);
    tick();
    check("rr_pending1_owner", owner, 1);
    finish_xfer(1, 1);
    // Client 0 alone, then a tie now goes to client 1
    req_rd = 2'b01;
    tick();
    check("solo0_owner", owner, 0);
    finish_xfer(0, 1);
    req_rd = 2'b11;
    tick();
    check("rr_after0_owner", owner, 1);
    finish_xfer(1, 1);
    tick();
    check("rr_last_owner", owner, 0);
    finish_xfer(0, 1);

    // Client 1 write with 512 buffer strobes during ack
    req_lba[1] = 32'h4000; req_wr = 2'b10;
    tick();
    check("wr_sd_wr", sd_wr, 1);
    check("wr_sd_rd", sd_rd, 0);
    check("wr_owner", owner, 1);
    check("wr_lba", sd_lba, 32'h4000);
    sd_ack = 1'b1; req_wr = 2'b00;
    for (int i = 0; i < 512; i++) begin
      d = 8'(i) ^ 8'hA5;
      sd_buff_wr = 1'b1;
      req_buff_din[1] = d;
      req_buff_din[0] = ~d;
      #1;
      check("wr_buff_wr", req_buff_wr, 2'b10);
      check("wr_buff_din", sd_buff_din, d);
      tick();
    end
    sd_buff_wr = 1'b0;
    #1 check("wr_buff_wr_off", req_buff_wr, 2'b00);
    sd_ack = 1'b0;
    tick();
    tick();
    check("wr_idle_busy", busy, 0);
    sd_buff_wr = 1'b1; sd_ack = 1'b1; req_buff_din[1] = 8'h77; req_buff_din[0] = 8'h11;
    #1;
    check("idle_buff_wr_drop", req_buff_wr, 2'b00);
    check("idle_buff_din_zero", sd_buff_din, 8'h00);
    check("idle_ack_drop", req_ack, 2'b00);
    sd_buff_wr = 1'b0; sd_ack = 1'b0;
    @(negedge CLK);

    // Reset asserted mid-transfer while ACTIVE with ack high
    req_lba[0] = 32'h55; req_rd = 2'b01;
    tick();
    sd_ack = 1'b1; req_rd = 2'b00;
    tick();
    check("mid_ack_before", req_ack, 2'b01);
    check("mid_busy_before", busy, 1);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sd_rd", sd_rd, 0);
    check("mid_rst_req_ack", req_ack, 2'b00);
    check("mid_rst_sd_lba", sd_lba, 0);
    sd_ack = 1'b0;
    #2 RESET_N = 1'b1;
    @(negedge CLK);
    req_lba[1] = 32'h66; req_rd = 2'b11;
    tick();
    check("post_rst_owner", owner, 0);
    check("post_rst_sd_rd", sd_rd, 1);
    check("post_rst_lba", sd_lba, 32'h55);
    finish_xfer(0, 1);
    tick();
    check("post_rst_c1_owner", owner, 1);
    check("post_rst_c1_lba", sd_lba, 32'h66);
    finish_xfer(1, 1);

    // No ack at all
    req_lba[0] = 32'h77; req_rd = 2'b01;
    tick();
`ifdef SD_ARB_TIMEOUT_EN
    k = 0;
    while (sd_rd && k < 100) begin
      k++;
      tick();
    end
    req_rd = 2'b00;
    check("tmo_issue_cycles", k, 16);
    check("tmo_req_err", req_err, 2'b01);
    check("tmo_busy_done", busy, 1);
    tick();
    check("tmo_req_err_off", req_err, 2'b00);
    check("tmo_busy_idle", busy, 0);
`else
    k = 0;
    repeat (40) begin
      if (sd_rd) k++;
      tick();
    end
    check("notmo_sd_rd_cycles", k, 40);
    check("notmo_sd_rd", sd_rd, 1);
    check("notmo_req_err", req_err, 2'b00);
    check("notmo_busy", busy, 1);
    finish_xfer(0, 1);
    check("notmo_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
